// File: rtl/maze_pkg.sv
// ============================================================================
// maze_pkg : heading/state types and turn helpers for the maze solver
// Rev 1.0
// ============================================================================
`default_nettype none

package maze_pkg;

  typedef enum logic [1:0] {
    NORTH = 2'd0,
    WEST  = 2'd1,
    SOUTH = 2'd2,
    EAST  = 2'd3
  } dir_t;

  localparam logic [11:0] HDNG_N = 12'h000;
  localparam logic [11:0] HDNG_W = 12'h3FF;
  localparam logic [11:0] HDNG_S = 12'h7FF;
  localparam logic [11:0] HDNG_E = 12'hC00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MV_ST = 3'd1,
    MV_WT = 3'd2,
    HD_ST = 3'd3,
    HD_WT = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic dir_t turn_left(input dir_t d);
    case (d)
      NORTH:   return WEST;
      WEST:    return SOUTH;
      SOUTH:   return EAST;
      default: return NORTH;
    endcase
  endfunction

  function automatic dir_t turn_right(input dir_t d);
    case (d)
      NORTH:   return EAST;
      EAST:    return SOUTH;
      SOUTH:   return WEST;
      default: return NORTH;
    endcase
  endfunction

  function automatic dir_t turn_180(input dir_t d);
    case (d)
      NORTH:   return SOUTH;
      SOUTH:   return NORTH;
      EAST:    return WEST;
      default: return EAST;
    endcase
  endfunction

  function automatic logic [11:0] dir_to_hdng(input dir_t d);
    case (d)
      NORTH:   return HDNG_N;
      WEST:    return HDNG_W;
      SOUTH:   return HDNG_S;
      default: return HDNG_E;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/maze_solver.sv
// ============================================================================
// maze_solver : wall-follower sequencer issuing move/heading commands to navigate
// Rev 1.0
// ============================================================================
`default_nettype none

module maze_solver
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_md_i,
  input  logic        cmd0_i,
  input  logic        lft_opn_i,
  input  logic        rght_opn_i,
  input  logic        mv_cmplt_i,
  input  logic        sol_cmplt_i,
  output logic        strt_hdng_o,
  output logic [11:0] dsrd_hdng_o,
  output logic        strt_mv_o,
  output logic        stp_lft_o,
  output logic        stp_rght_o
);

  state_t state_q, state_d;
  dir_t   dir_q, dir_d;
  logic   aff_q, aff_d;
  logic   strt_mv_q, strt_mv_d;
  logic   strt_hdng_q, strt_hdng_d;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    aff_d       = aff_q;
    strt_mv_d   = 1'b0;
    strt_hdng_d = 1'b0;
    // Handing nav back to the command processor overrides everything else.
    if (cmd_md_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          aff_d   = cmd0_i;
          state_d = MV_ST;
        end
        MV_ST: begin
          strt_mv_d = 1'b1;
          state_d   = MV_WT;
        end
        MV_WT: begin
          if (mv_cmplt_i) begin
            if (sol_cmplt_i) begin
              state_d = DONE;
            end else begin
              if (aff_q)
                dir_d = lft_opn_i  ? turn_left(dir_q)  :
                        rght_opn_i ? turn_right(dir_q) : turn_180(dir_q);
              else
                dir_d = rght_opn_i ? turn_right(dir_q) :
                        lft_opn_i  ? turn_left(dir_q)  : turn_180(dir_q);
              state_d = HD_ST;
            end
          end
        end
        HD_ST: begin
          strt_hdng_d = 1'b1;
          state_d     = HD_WT;
        end
        HD_WT: begin
          if (mv_cmplt_i)
            state_d = sol_cmplt_i ? DONE : MV_ST;
        end
        default: state_d = DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= NORTH;
      aff_q       <= 1'b1;
      strt_mv_q   <= 1'b0;
      strt_hdng_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      aff_q       <= aff_d;
      strt_mv_q   <= strt_mv_d;
      strt_hdng_q <= strt_hdng_d;
    end
  end

  assign strt_mv_o   = strt_mv_q;
  assign strt_hdng_o = strt_hdng_q;
  assign dsrd_hdng_o = dir_to_hdng(dir_q);
  assign stp_lft_o   = (state_q != IDLE) &  aff_q;
  assign stp_rght_o  = (state_q != IDLE) & ~aff_q;

endmodule

`default_nettype wire

// File: tb/tb_maze_solver.sv
// ============================================================================
// tb_maze_solver : directed self-checking bench for maze_solver
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_maze_solver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_md = 1'b1;
  logic        cmd0 = 1'b0;
  logic        lft_opn = 1'b0;
  logic        rght_opn = 1'b0;
  logic        mv_cmplt = 1'b0;
  logic        sol_cmplt = 1'b0;
  logic        strt_hdng;
  logic [11:0] dsrd_hdng;
  logic        strt_mv;
  logic        stp_lft;
  logic        stp_rght;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  int  m_dir = 0;
  bit  m_aff = 1'b1;

  always #5 clk = ~clk;

  maze_solver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_md_i    (cmd_md),
    .cmd0_i      (cmd0),
    .lft_opn_i   (lft_opn),
    .rght_opn_i  (rght_opn),
    .mv_cmplt_i  (mv_cmplt),
    .sol_cmplt_i (sol_cmplt),
    .strt_hdng_o (strt_hdng),
    .dsrd_hdng_o (dsrd_hdng),
    .strt_mv_o   (strt_mv),
    .stp_lft_o   (stp_lft),
    .stp_rght_o  (stp_rght)
  );

  function automatic logic [11:0] hd(input int d);
    case (d)
      0:       return 12'h000;
      1:       return 12'h3FF;
      2:       return 12'h7FF;
      default: return 12'hC00;
    endcase
  endfunction

  // Directions indexed N=0, W=1, S=2, E=3 so a left turn is +1 mod 4.
  function automatic int mturn(input int d, input bit aff, input bit l, input bit r);
    if (aff) return l ? (d + 1) % 4 : r ? (d + 3) % 4 : (d + 2) % 4;
    else     return r ? (d + 3) % 4 : l ? (d + 1) % 4 : (d + 2) % 4;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mv(input bit l, input bit r, input bit sol);
    lft_opn = l; rght_opn = r; sol_cmplt = sol; mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0; sol_cmplt = 1'b0;
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, {10'd0, strt_mv, strt_hdng}, 12'd0);
      tick();
    end
  endtask

  task automatic wait_strt_mv(input string tag);
    int k;
    k = 0;
    while (!strt_mv && k < 20) begin tick(); k++; end
    check({tag, "_seen"}, {11'd0, strt_mv}, 12'd1);
    check({tag, "_hdng"}, dsrd_hdng, hd(m_dir));
    tick();
    check({tag, "_1cyc"}, {11'd0, strt_mv}, 12'd0);
  endtask

  task automatic wait_strt_hdng(input string tag);
    int k;
    logic [11:0] e;
    k = 0;
    while (!strt_hdng && k < 20) begin tick(); k++; end
    check({tag, "_seen"}, {11'd0, strt_hdng}, 12'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 12'd1, {11'd0, strt_hdng ^ strt_hdng});
    end else begin
      e = exp_q.pop_front();
      check({tag, "_dsrd"}, dsrd_hdng, e);
    end
    tick();
    check({tag, "_1cyc"}, {11'd0, strt_hdng}, 12'd0);
  endtask

  // Full move/turn cycle starting in MV_WT; ends back in MV_WT.
  task automatic do_turn(input string tag, input bit l, input bit r);
    m_dir = mturn(m_dir, m_aff, l, r);
    exp_q.push_back(hd(m_dir));
    pulse_mv(l, r, 1'b0);
    wait_strt_hdng(tag);
    pulse_mv(1'b0, 1'b0, 1'b0);
    wait_strt_mv({tag, "_mv"});
  endtask

  initial begin
    // 1. reset state and first move
    #2;
    check("rst_strt_mv", {11'd0, strt_mv}, 12'd0);
    check("rst_strt_hdng", {11'd0, strt_hdng}, 12'd0);
    check("rst_dsrd", dsrd_hdng, 12'h000);
    check("rst_stp", {10'd0, stp_lft, stp_rght}, 12'd0);
    tick();
    rst_n = 1'b1;
    tick();
    cmd0 = 1'b1; cmd_md = 1'b0; m_aff = 1'b1;
    tick();
    check("lat_mv_early", {11'd0, strt_mv}, 12'd0);
    tick();
    check("lat_mv", {11'd0, strt_mv}, 12'd1);
    check("t1_stp_lft", {11'd0, stp_lft}, 12'd1);
    check("t1_stp_rght", {11'd0, stp_rght}, 12'd0);
    check("t1_dsrd", dsrd_hdng, 12'h000);
    tick();
    check("t1_mv_1cyc", {11'd0, strt_mv}, 12'd0);

    // 2. left affinity, both open -> left (W), with exact latency
    m_dir = mturn(m_dir, m_aff, 1'b1, 1'b1);
    exp_q.push_back(hd(m_dir));
    pulse_mv(1'b1, 1'b1, 1'b0);
    check("t2_dsrd_early", dsrd_hdng, 12'h3FF);
    check("t2_hdng_early", {11'd0, strt_hdng}, 12'd0);
    wait_strt_hdng("t2");
    quiet("t2_hd_wait", 3);
    pulse_mv(1'b0, 1'b0, 1'b0);
    wait_strt_mv("t2_mv");
    do_turn("t2_right", 1'b0, 1'b1);
    do_turn("t2_180", 1'b0, 1'b0);

    // 3. switch to right affinity; S -> E (left), then 180 E -> W
    cmd_md = 1'b1;
    tick();
    check("t3_idle_stp", {10'd0, stp_lft, stp_rght}, 12'd0);
    check("t3_idle_hold", dsrd_hdng, hd(m_dir));
    cmd0 = 1'b0; cmd_md = 1'b0; m_aff = 1'b0;
    wait_strt_mv("t3_mv");
    check("t3_stp_rght", {10'd0, stp_lft, stp_rght}, 12'd1);
    do_turn("t3_to_e", 1'b1, 1'b0);
    check("t3_at_e", dsrd_hdng, 12'hC00);
    do_turn("t3_180", 1'b0, 1'b0);
    check("t3_w", dsrd_hdng, 12'h3FF);
    check("t3_stp_rght2", {11'd0, stp_rght}, 12'd1);

    // 4. back to N, then four right turns with wrap-around
    do_turn("t4_to_n", 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) do_turn("t4_right", 1'b1, 1'b1);
    check("t4_wrap", dsrd_hdng, 12'h000);

    // sol_cmplt without mv_cmplt does nothing
    sol_cmplt = 1'b1;
    tick();
    sol_cmplt = 1'b0;
    quiet("sol_alone", 3);
    do_turn("sol_alone_turn", 1'b0, 1'b0);

    // 5. solution reached
    pulse_mv(1'b1, 1'b1, 1'b1);
    quiet("t5_done", 6);
    check("t5_hold", dsrd_hdng, hd(m_dir));
    check("t5_done_stp", {10'd0, stp_lft, stp_rght}, 12'd1);
    cmd_md = 1'b1;
    tick();
    check("t5_idle_stp", {10'd0, stp_lft, stp_rght}, 12'd0);

    // 6. abort in HD_WT, stray mv_cmplt in IDLE, restart from held heading
    cmd0 = 1'b1; cmd_md = 1'b0; m_aff = 1'b1;
    wait_strt_mv("t6_mv");
    m_dir = mturn(m_dir, m_aff, 1'b1, 1'b0);
    exp_q.push_back(hd(m_dir));
    pulse_mv(1'b1, 1'b0, 1'b0);
    wait_strt_hdng("t6");
    cmd_md = 1'b1;
    quiet("t6_abort", 2);
    pulse_mv(1'b1, 1'b1, 1'b0);
    quiet("t6_ignored", 3);
    check("t6_hold", dsrd_hdng, hd(m_dir));
    check("t6_idle_stp", {10'd0, stp_lft, stp_rght}, 12'd0);
    cmd_md = 1'b0;
    wait_strt_mv("t6_restart");
    do_turn("t6_turn", 1'b0, 1'b1);

    // asynchronous reset mid-sequence
    rst_n = 1'b0;
    #1;
    check("arst_dsrd", dsrd_hdng, 12'h000);
    check("arst_stp", {10'd0, stp_lft, stp_rght}, 12'd0);
    check("arst_pulses", {10'd0, strt_mv, strt_hdng}, 12'd0);
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
